alu_key_sequencer: RTL and testbench

Front-end controller between the board's raw push-buttons/switches and the ALU operand/result datapath. Synchronizes and debounces two active-low keys, runs the operand-entry sequence (operand A → operand B → equals), and issues the ALU's active-low, one-cycle `load1`/`load2`/`equal` strobes with a registered `number` operand. Also synchronizes the four operation-select switches and forwards them to the ALU's `mux1..mux4` inputs.

---
 rtl/alu_key_sequencer.sv | 108 ++++++++++
 tb/tb_alu_key_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_key_sequencer.sv
// alu_key_sequencer: debounced key sequencer driving ALU operand/equal strobes
module alu_key_sequencer #(
  parameter int N = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load_n,
  input  logic         key_equal_n,
  input  logic [N-1:0] sw_number,
  input  logic [3:0]   sw_op,
  output logic [N-1:0] number,
  output logic         load1,
  output logic         load2,
  output logic         equal,
  output logic         mux1,
  output logic         mux2,
  output logic         mux3,
  output logic         mux4,
  output logic [1:0]   state
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, WAIT_EQ, RESULT} state_t;
  logic [1:0]   keys;
  logic [1:0]   press;
  logic [N-1:0] num_s1_q, num_s2_q;
  logic [3:0]   op_s1_q, op_s2_q;
  logic [N-1:0] number_q;
  logic         load1_q, load2_q, equal_q;
  state_t       state_q;
  logic         ld_ev, eq_ev;
  assign keys = {key_equal_n, key_load_n};
  genvar k;
  generate
    for (k = 0; k < 2; k++) begin : g_key
      logic s1_q, s2_q, db_q, dbp_q;
      logic [CW-1:0] cnt_q;
      // synchronize the key, then accept a new level only after it holds for DEBOUNCE_CYCLES
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          s1_q  <= 1'b1;
          s2_q  <= 1'b1;
          db_q  <= 1'b1;
          dbp_q <= 1'b1;
          cnt_q <= '0;
        end else begin
          s1_q  <= keys[k];
          s2_q  <= s1_q;
          dbp_q <= db_q;
          if (s2_q == db_q) cnt_q <= '0;
          else if (cnt_q == CNT_LAST) begin
            db_q  <= s2_q;
            cnt_q <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        end
      assign press[k] = dbp_q & ~db_q;
    end
  endgenerate
  // two-flop synchronizers for the operand and operation switches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      num_s1_q <= '0;
      num_s2_q <= '0;
      op_s1_q  <= '0;
      op_s2_q  <= '0;
    end else begin
      num_s1_q <= sw_number;
      num_s2_q <= num_s1_q;
      op_s1_q  <= sw_op;
      op_s2_q  <= op_s1_q;
    end
  assign ld_ev = press[0];
  assign eq_ev = press[1] & (state_q == WAIT_EQ || state_q == RESULT);
  // sequencer: a valid equal wins over a simultaneous load; strobes last one cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= LOAD_A;
      number_q <= '0;
      load1_q  <= 1'b1;
      load2_q  <= 1'b1;
      equal_q  <= 1'b1;
    end else begin
      load1_q <= 1'b1;
      load2_q <= 1'b1;
      equal_q <= 1'b1;
      if (eq_ev) begin
        equal_q  <= 1'b0;
        number_q <= num_s2_q;
        state_q  <= RESULT;
      end else if (ld_ev) begin
        number_q <= num_s2_q;
        if (state_q == LOAD_A || state_q == RESULT) begin
          load1_q <= 1'b0;
          state_q <= LOAD_B;
        end else begin
          load2_q <= 1'b0;
          state_q <= WAIT_EQ;
        end
      end
    end
  assign number = number_q;
  assign load1  = load1_q;
  assign load2  = load2_q;
  assign equal  = equal_q;
  assign state  = state_q;
  assign {mux4, mux3, mux2, mux1} = op_s2_q;
endmodule

// File: tb/tb_alu_key_sequencer.sv
// tb_alu_key_sequencer: directed and random checks against an abstract sequencer model
module tb_alu_key_sequencer;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_load_n = 1'b1, key_equal_n = 1'b1;
  logic [N-1:0] sw_number = '0;
  logic [3:0] sw_op = '0;
  logic [N-1:0] number;
  logic load1, load2, equal, mux1, mux2, mux3, mux4;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  int exp_st = 0;
  logic [N-1:0] exp_num = '0;

  alu_key_sequencer #(.N(N), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_load_n(key_load_n), .key_equal_n(key_equal_n),
    .sw_number(sw_number), .sw_op(sw_op), .number(number), .load1(load1),
    .load2(load2), .equal(equal), .mux1(mux1), .mux2(mux2), .mux3(mux3),
    .mux4(mux4), .state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 none, 1 load1, 2 load2, 3 equal
  function automatic logic [2:0] strobe_of(input int kind);
    return kind == 1 ? 3'b011 : kind == 2 ? 3'b101 : kind == 3 ? 3'b110 : 3'b111;
  endfunction

  // operand-entry rules: a new calculation starts from LOAD_A or RESULT
  task automatic model(input int st, input bit ld, input bit eq, output int nst, output int kind);
    bit fresh;
    fresh = (st == 0) || (st == 3);
    if (eq && st >= 2) begin
      kind = 3;
      nst = 3;
    end else if (ld) begin
      kind = fresh ? 1 : 2;
      nst = fresh ? 1 : 2;
    end else begin
      kind = 0;
      nst = st;
    end
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) begin
      cyc();
      chk(tag, {27'b0, state, load1, load2, equal}, {27'b0, 2'(exp_st), 3'b111});
      chk({tag, "_num"}, 32'(number), 32'(exp_num));
    end
  endtask

  // press raw key(s) for hold cycles; the strobe is due on the 7th edge
  task automatic press(input bit ld, input bit eq, input int hold, input logic [N-1:0] num);
    int kind, nst;
    model(exp_st, ld, eq, nst, kind);
    sw_number = num;
    if (ld) key_load_n = 1'b0;
    if (eq) key_equal_n = 1'b0;
    for (int i = 1; i <= hold + 14; i++) begin
      cyc();
      if (i == 7) begin
        exp_st = nst;
        if (kind != 0) exp_num = num;
      end
      chk("press_strobe", {29'b0, load1, load2, equal}, {29'b0, (i == 7) ? strobe_of(kind) : 3'b111});
      chk("press_state", 32'(state), 32'(exp_st));
      chk("press_number", 32'(number), 32'(exp_num));
      if (i == hold) begin
        key_load_n = 1'b1;
        key_equal_n = 1'b1;
      end
    end
  endtask

  initial begin
    logic [3:0] ops [7];
    logic [3:0] prev_op;
    int r;
    ops = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b0010, 4'b0001, 4'b1001};
    repeat (3) cyc();
    chk("reset_strobes", {29'b0, load1, load2, equal}, 32'h7);
    chk("reset_number", 32'(number), 32'h0);
    chk("reset_state", 32'(state), 32'h0);
    chk("reset_mux", {28'b0, mux4, mux3, mux2, mux1}, 32'h0);
    rst = 1'b0;
    idle(50, "idle_after_reset");
    press(1'b1, 1'b0, 20, 4'b0101);
    press(1'b1, 1'b0, 20, 4'b0011);
    press(1'b0, 1'b1, 20, 4'b0011);
    key_load_n = 1'b0;
    idle(2, "bounce");
    key_load_n = 1'b1;
    idle(2, "bounce");
    key_load_n = 1'b0;
    idle(3, "bounce");
    key_load_n = 1'b1;
    idle(20, "bounce");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_st = 0;
    exp_num = '0;
    press(1'b0, 1'b1, 10, 4'(($urandom)));
    press(1'b1, 1'b0, 10, 4'(($urandom)));
    press(1'b1, 1'b0, 10, 4'(($urandom)));
    press(1'b1, 1'b1, 10, 4'(($urandom)));
    prev_op = sw_op;
    for (int i = 0; i < 7; i++) begin
      sw_op = ops[i];
      cyc();
      chk("op_hold", {28'b0, mux4, mux3, mux2, mux1}, {28'b0, prev_op});
      cyc();
      chk("op_pass", {28'b0, mux4, mux3, mux2, mux1}, {28'b0, ops[i]});
      chk("op_no_strobe", {29'b0, load1, load2, equal}, 32'h7);
      prev_op = ops[i];
    end
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(2, 0);
      press(r != 1, r != 0, $urandom_range(16, 4), 4'($urandom));
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_st = 0;
    exp_num = '0;
    press(1'b1, 1'b0, 10, 4'b1010);
    sw_number = 4'b0110;
    key_load_n = 1'b0;
    repeat (7) cyc();
    chk("mid_load2_low", {29'b0, load1, load2, equal}, 32'h5);
    rst = 1'b1;
    key_load_n = 1'b1;
    #1;
    chk("mid_rst_strobe", {29'b0, load1, load2, equal}, 32'h7);
    chk("mid_rst_state", 32'(state), 32'h0);
    chk("mid_rst_number", 32'(number), 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
    exp_st = 0;
    exp_num = '0;
    idle(15, "after_mid_rst");
    press(1'b1, 1'b0, 10, 4'b1111);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
